// File: rtl/programmable_rate_counter.sv
// Programmable-period tick divider driving a modulo up/down counter with a one-cycle wrap pulse.
// Parallel load is compiled in only when PROGRAMMABLE_RATE_COUNTER_LOAD_EN is defined.
module programmable_rate_counter #(
  parameter int DIV_W   = 11,
  parameter int CNT_W   = 4,
  parameter int DIV0    = 1,
  parameter int DIV1    = 500,
  parameter int DIV2    = 1000,
  parameter int DIV3    = 2000,
  parameter int CNT_MAX = 15
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic [1:0]       Speed,
  input  logic             Run,
  input  logic             Up,
  input  logic             Load,
  input  logic [CNT_W-1:0] LoadValue,
  output logic             Tick,
  output logic [CNT_W-1:0] CounterValue,
  output logic             Wrap
);

  localparam logic [DIV_W-1:0] RL0   = DIV_W'(DIV0 - 1);
  localparam logic [DIV_W-1:0] RL1   = DIV_W'(DIV1 - 1);
  localparam logic [DIV_W-1:0] RL2   = DIV_W'(DIV2 - 1);
  localparam logic [DIV_W-1:0] RL3   = DIV_W'(DIV3 - 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(CNT_MAX);

  logic [DIV_W-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;
  logic [DIV_W-1:0] w_reload;
  logic             w_tick;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;

  always_comb begin
    w_reload = RL0;
    case (Speed)
      2'b00:   w_reload = RL0;
      2'b01:   w_reload = RL1;
      2'b10:   w_reload = RL2;
      default: w_reload = RL3;
    endcase
  end

`ifdef PROGRAMMABLE_RATE_COUNTER_LOAD_EN
  assign w_load     = Load;
  assign w_load_val = (LoadValue > C_MAX) ? C_MAX : LoadValue;
`else
  logic w_unused_load;
  assign w_unused_load = ^{Load, LoadValue};
  assign w_load        = 1'b0;
  assign w_load_val    = '0;
`endif

  assign w_tick = Run & (r_q == '0);

  // Speed is only looked at on reload, so a mid-interval change never distorts tick spacing.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_q <= w_reload;
    end else if (w_load) begin
      r_q <= w_reload;
    end else if (!Run) begin
      r_q <= r_q;
    end else if (r_q == '0) begin
      r_q <= w_reload;
    end else begin
      r_q <= r_q - 1'b1;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= w_load_val;
      r_wrap <= 1'b0;
    end else if (w_tick && Up) begin
      if (r_cnt == C_MAX) begin
        r_cnt  <= '0;
        r_wrap <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_wrap <= 1'b0;
      end
    end else if (w_tick) begin
      if (r_cnt == '0) begin
        r_cnt  <= C_MAX;
        r_wrap <= 1'b1;
      end else begin
        r_cnt  <= r_cnt - 1'b1;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign Tick         = w_tick;
  assign CounterValue = r_cnt;
  assign Wrap         = r_wrap;

endmodule

// File: tb/tb_programmable_rate_counter.sv
// Bench for programmable_rate_counter: directed scenarios plus random traffic against an
// elapsed-time / modulo-arithmetic reference model.
module tb_programmable_rate_counter;

  localparam int TB_DIV0 = 1;
  localparam int TB_DIV1 = 3;
  localparam int TB_DIV2 = 5;
  localparam int TB_DIV3 = 8;
  localparam int TB_CMAX = 9;
`ifdef PROGRAMMABLE_RATE_COUNTER_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] speed = 2'd1;
  logic       run = 1'b1;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       tick;
  logic [3:0] cnt;
  logic       wrap;

  programmable_rate_counter #(
    .DIV_W(4), .CNT_W(4), .DIV0(TB_DIV0), .DIV1(TB_DIV1), .DIV2(TB_DIV2),
    .DIV3(TB_DIV3), .CNT_MAX(TB_CMAX)
  ) dut (
    .ClockIn(clk), .Reset(rst), .Speed(speed), .Run(run), .Up(up), .Load(load),
    .LoadValue(load_val), .Tick(tick), .CounterValue(cnt), .Wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: period latched at each reload, elapsed clocks within the interval.
  int m_per   = 1;
  int m_el    = 0;
  int m_cnt   = 0;
  bit m_wrap  = 1'b0;
  bit m_valid = 1'b0;

  int obs_tick, obs_cnt, obs_wrap;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sel_per(input logic [1:0] s);
    case (s)
      2'd0:    return TB_DIV0;
      2'd1:    return TB_DIV1;
      2'd2:    return TB_DIV2;
      default: return TB_DIV3;
    endcase
  endfunction

  function automatic bit m_tick();
    return run && (m_el == m_per - 1);
  endfunction

  task automatic model_edge();
    bit t;
    t = m_tick();
    if (rst) begin
      m_per = sel_per(speed); m_el = 0; m_cnt = 0; m_wrap = 1'b0; m_valid = 1'b1;
    end else if (LOAD_EN && load) begin
      m_per = sel_per(speed); m_el = 0; m_wrap = 1'b0;
      m_cnt = (int'(load_val) > TB_CMAX) ? TB_CMAX : int'(load_val);
    end else begin
      m_wrap = 1'b0;
      if (t) begin
        if (up) begin
          m_cnt  = (m_cnt + 1) % (TB_CMAX + 1);
          m_wrap = (m_cnt == 0);
        end else begin
          m_cnt  = (m_cnt + TB_CMAX) % (TB_CMAX + 1);
          m_wrap = (m_cnt == TB_CMAX);
        end
      end
      if (run) begin
        if (m_el == m_per - 1) begin
          m_per = sel_per(speed);
          m_el  = 0;
        end else begin
          m_el++;
        end
      end
    end
  endtask

  // One clock: sample at negedge, compare to model, then advance model on the posedge.
  task automatic step();
    @(negedge clk);
    obs_tick = int'(tick);
    obs_cnt  = int'(cnt);
    obs_wrap = int'(wrap);
    if (m_valid) begin
      chk("tick", obs_tick, int'(m_tick()));
      chk("count", obs_cnt, m_cnt);
      chk("wrap", obs_wrap, int'(m_wrap));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input logic [1:0] s, input logic u);
    rst = 1'b1; speed = s; up = u; run = 1'b1; load = 1'b0; load_val = 4'd0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int first, second, third, ticks;

    // Speed 01 counting up through a wrap.
    do_reset(2'd1, 1'b1);
    first = -1; ticks = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (c == 0) begin
        chk("t1_reset_cnt", obs_cnt, 0);
        chk("t1_reset_wrap", obs_wrap, 0);
        chk("t1_reset_tick", obs_tick, 0);
      end
      if (c == 3)  chk("t1_cnt_after_first", obs_cnt, 1);
      if (c == 27) chk("t1_cnt_after_9th", obs_cnt, 9);
      if (obs_tick == 1) begin
        if (first < 0) first = c;
        ticks++;
      end
    end
    chk("t1_first_tick", first, 2);
    chk("t1_tick_count", ticks, 10);
    step();
    chk("t1_cnt_after_10th", obs_cnt, 0);
    chk("t1_wrap_after_10th", obs_wrap, 1);
    step();
    chk("t1_wrap_one_clock", obs_wrap, 0);

    // Speed 00: tick every clock.
    do_reset(2'd0, 1'b1);
    for (int c = 0; c < 25; c++) begin
      step();
      chk("t2_tick", obs_tick, 1);
      chk("t2_cnt", obs_cnt, c % 10);
      chk("t2_wrap", obs_wrap, (c >= 10 && c % 10 == 0) ? 1 : 0);
    end

    // Counting down from reset.
    do_reset(2'd1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 3) begin
        chk("t3_first_down", obs_cnt, 9);
        chk("t3_first_wrap", obs_wrap, 1);
      end
      if (c == 6) begin
        chk("t3_second_down", obs_cnt, 8);
        chk("t3_second_wrap", obs_wrap, 0);
      end
      if (c == 9) chk("t3_third_down", obs_cnt, 7);
    end

    // Speed change mid-interval finishes the old interval.
    do_reset(2'd3, 1'b1);
    first = -1; second = -1; third = -1;
    for (int c = 0; c < 16; c++) begin
      if (c == 3) speed = 2'd1;
      step();
      if (obs_tick == 1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
        else if (third < 0) third = c;
      end
    end
    chk("t4_old_interval_tick", first, 7);
    chk("t4_new_period_tick1", second, 10);
    chk("t4_new_period_tick2", third, 13);

    // Pause while q is 1.
    do_reset(2'd2, 1'b1);
    first = -1; ticks = 0;
    for (int c = 0; c < 14; c++) begin
      run = (c >= 3 && c < 10) ? 1'b0 : 1'b1;
      step();
      if (c >= 3 && c < 10) begin
        ticks += obs_tick;
        chk("t5_paused_cnt", obs_cnt, 0);
      end
      if (obs_tick == 1 && first < 0) first = c;
    end
    chk("t5_paused_ticks", ticks, 0);
    chk("t5_resume_tick", first, 11);

    // Load on a tick cycle.
    do_reset(2'd1, 1'b1);
    first = -1;
    for (int c = 0; c < 8; c++) begin
      load     = (c == 2) ? 1'b1 : 1'b0;
      load_val = 4'd12;
      step();
      if (c == 3) chk("t6_after_load", obs_cnt, LOAD_EN ? 9 : 1);
      if (c > 2 && obs_tick == 1 && first < 0) first = c;
      if (c == 6) chk("t6_next_step", obs_cnt, LOAD_EN ? 0 : 2);
    end
    load = 1'b0;
    chk("t6_next_tick", first, 5);

    // Random traffic.
    do_reset(2'd0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(63) == 0);
      speed    = 2'($urandom_range(3));
      run      = ($urandom_range(7) != 0);
      up       = 1'($urandom_range(1));
      load     = ($urandom_range(15) == 0);
      load_val = 4'($urandom_range(15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
